// File: rtl/producer_fsm.sv
// Two-lane burst producer.
// On an accepted start it captures base/stride/count and generates the
// arithmetic sequence base + k*stride. Items go one per cycle into two
// valid/ready output lanes. Lane choice is round-robin, with fallback to
// the other lane when the preferred one is stalled. An abort stops further
// issue, and items already in the lanes are still delivered.
module producer_fsm #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] stride,
    input  logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] pipeline1_inputs,
    output logic [DATA_W-1:0] pipeline2_inputs,
    output logic [1:0]        valid,
    input  logic [1:0]        ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  issued
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_stride;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_issued;
    logic [DATA_W-1:0] r_lane0;
    logic [DATA_W-1:0] r_lane1;
    logic [1:0]        r_valid;
    logic              r_rr;
    logic              r_aborted;
    logic              r_busy;
    logic              r_done;

    logic [1:0]        w_free;
    logic [1:0]        w_xfer;
    logic [CNT_W-1:0]  w_issued_inc;
    logic              w_accept;
    logic              w_load;
    logic              w_load_lane;
    logic              w_abort_hit;

    // A lane can take a new item if it is empty or its current item leaves this cycle.
    assign w_free       = ~r_valid | ready;
    assign w_xfer       = r_valid & ready;
    assign w_issued_inc = r_issued + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state and issue decisions. Abort wins over any load in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_load_lane  = 1'b0;
        w_abort_hit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (count == {CNT_W{1'b0}}) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = ISSUE;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    w_abort_hit  = 1'b1;
                    w_state_next = DRAIN;
                end else if (w_free[r_rr]) begin
                    w_load      = 1'b1;
                    w_load_lane = r_rr;
                end else if (w_free[~r_rr]) begin
                    w_load      = 1'b1;
                    w_load_lane = ~r_rr;
                end else begin
                    w_load = 1'b0;
                end
                if (w_load && (w_issued_inc == r_count)) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = w_state_next;
                end
            end
            DRAIN: begin
                if (&w_free) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Burst configuration, running data accumulator, issue count and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= {DATA_W{1'b0}};
            r_stride  <= {DATA_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_issued  <= {CNT_W{1'b0}};
            r_rr      <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc     <= base;
                r_stride  <= stride;
                r_count   <= count;
                r_issued  <= {CNT_W{1'b0}};
                r_aborted <= 1'b0;
            end
            if (w_load) begin
                r_acc    <= r_acc + r_stride;
                r_issued <= w_issued_inc;
                r_rr     <= ~w_load_lane;
            end
            if (w_abort_hit) begin
                r_aborted <= 1'b1;
            end
        end
    end

    // Lane registers: load sets valid, a transfer without reload clears it, a stall holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane0 <= {DATA_W{1'b0}};
            r_lane1 <= {DATA_W{1'b0}};
            r_valid <= 2'b00;
        end else begin
            if (w_load && (w_load_lane == 1'b0)) begin
                r_lane0    <= r_acc;
                r_valid[0] <= 1'b1;
            end else if (w_xfer[0]) begin
                r_valid[0] <= 1'b0;
            end
            if (w_load && (w_load_lane == 1'b1)) begin
                r_lane1    <= r_acc;
                r_valid[1] <= 1'b1;
            end else if (w_xfer[1]) begin
                r_valid[1] <= 1'b0;
            end
        end
    end

    // Status flags registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next != IDLE);
            r_done <= (w_state_next == DONE);
        end
    end

    assign pipeline1_inputs = r_lane0;
    assign pipeline2_inputs = r_lane1;
    assign valid            = r_valid;
    assign busy             = r_busy;
    assign done             = r_done;
    assign aborted          = r_aborted;
    assign issued           = r_issued;

endmodule

// File: tb/tb_producer_fsm.sv
// Scoreboard bench for producer_fsm.
// Each expected lane transfer (cycle, lane, data) is queued when a burst is
// set up. The queued entry is popped and compared when the DUT shows
// valid & ready on that lane.
module tb_producer_fsm;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] base;
    logic [31:0] stride;
    logic [15:0] count;
    logic [31:0] pipeline1_inputs;
    logic [31:0] pipeline2_inputs;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] issued;

    producer_fsm #(.DATA_W(32), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .base             (base),
        .stride           (stride),
        .count            (count),
        .pipeline1_inputs (pipeline1_inputs),
        .pipeline2_inputs (pipeline2_inputs),
        .valid            (valid),
        .ready            (ready),
        .busy             (busy),
        .done             (done),
        .aborted          (aborted),
        .issued           (issued)
    );

    typedef struct {
        int          cyc;
        int          lane;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_chk;
    int          n_bad;
    int          cyc;
    logic [1:0]  hold_pend;
    logic [31:0] hold_data[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input int l, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.lane = l;
        e.data = d;
        sb.push_back(e);
    endtask

    // Called at the falling edge: check stalled lanes held still, then score transfers.
    task automatic monitor();
        logic [31:0] d;
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            d = (i == 0) ? pipeline1_inputs : pipeline2_inputs;
            if (hold_pend[i]) begin
                chk("hold_valid", valid[i], 1);
                chk("hold_data", d, hold_data[i]);
            end
            if (valid[i] && ready[i]) begin
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("xfer_cyc", cyc, e.cyc);
                    chk("xfer_lane", i, e.lane);
                    chk("xfer_data", d, e.data);
                end
            end
            hold_pend[i] = valid[i] && !ready[i] && !reset;
            hold_data[i] = d;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // One burst: start in cycle 0, ready held at rdy0 until cycle rdy_cyc, abort pulsed at abort_cyc.
    task automatic run_burst(input logic [31:0] b, input logic [31:0] s, input logic [15:0] n,
                             input logic [1:0] rdy0, input int rdy_cyc, input int abort_cyc,
                             input int exp_done, input logic exp_ab, input logic [15:0] exp_iss);
        bit got;
        got    = 1'b0;
        base   = b;
        stride = s;
        count  = n;
        for (int k = 0; k < 40; k++) begin
            cyc   = k;
            start = (k == 0);
            abort = (k == abort_cyc);
            ready = (k >= rdy_cyc) ? 2'b11 : rdy0;
            sample();
            if (k == 1) chk("busy_c1", busy, 1);
            if (done === 1'b1) begin
                got = 1'b1;
                chk("done_cyc", k, exp_done);
                chk("aborted", aborted, exp_ab);
                chk("issued", issued, exp_iss);
                chk("valid_at_done", valid, 2'b00);
            end
            advance();
            if (got) break;
        end
        if (!got) chk("done_timeout", got, 1);
        start = 1'b0;
        abort = 1'b0;
        cyc   = cyc + 1;
        sample();
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("sb_empty", sb.size(), 0);
        sb.delete();
        advance();
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        cyc       = 0;
        hold_pend = 2'b00;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        ready     = 2'b11;
        base      = 32'h0;
        stride    = 32'h0;
        count     = 16'h0;
        advance();
        advance();
        sample();
        chk("rst_valid", valid, 2'b00);
        chk("rst_lane0", pipeline1_inputs, 32'h0);
        chk("rst_lane1", pipeline2_inputs, 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_issued", issued, 16'h0);
        reset = 1'b0;
        advance();

        // Normal burst with an always-ready consumer.
        push_exp(2, 0, 32'h10);
        push_exp(3, 1, 32'h14);
        push_exp(4, 0, 32'h18);
        push_exp(5, 1, 32'h1C);
        run_burst(32'h10, 32'h4, 16'd4, 2'b11, 0, -1, 6, 1'b0, 16'd4);

        // Zero-length burst goes straight to DONE.
        run_burst(32'h55, 32'h1, 16'd0, 2'b11, 0, -1, 1, 1'b0, 16'd0);

        // Accumulator wraps modulo 2^32.
        push_exp(2, 0, 32'hFFFF_FFFC);
        push_exp(3, 1, 32'h0000_0004);
        run_burst(32'hFFFF_FFFC, 32'h8, 16'd2, 2'b11, 0, -1, 4, 1'b0, 16'd2);

        // Lane 0 stalled: item 0 holds there, items 1 and 2 use lane 1.
        push_exp(3, 1, 32'h14);
        push_exp(4, 1, 32'h18);
        push_exp(6, 0, 32'h10);
        run_burst(32'h10, 32'h4, 16'd3, 2'b10, 6, -1, 7, 1'b0, 16'd3);

        // Reset in the middle of a burst discards lane contents.
        push_exp(2, 0, 32'h10);
        push_exp(3, 1, 32'h14);
        base   = 32'h10;
        stride = 32'h4;
        count  = 16'd4;
        ready  = 2'b11;
        for (int k = 0; k < 5; k++) begin
            cyc   = k;
            start = (k == 0);
            reset = (k == 3);
            sample();
            if (k == 4) begin
                chk("mid_rst_valid", valid, 2'b00);
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_issued", issued, 16'h0);
                chk("mid_rst_lane0", pipeline1_inputs, 32'h0);
                chk("mid_rst_lane1", pipeline2_inputs, 32'h0);
                chk("mid_rst_done", done, 0);
            end
            advance();
        end
        chk("mid_rst_sb", sb.size(), 0);
        sb.delete();
        push_exp(2, 0, 32'h10);
        push_exp(3, 1, 32'h14);
        push_exp(4, 0, 32'h18);
        push_exp(5, 1, 32'h1C);
        run_burst(32'h10, 32'h4, 16'd4, 2'b11, 0, -1, 6, 1'b0, 16'd4);

        // Abort in cycle 4 with lane 0 stalled: three items issued, held item still delivered.
        push_exp(3, 1, 32'h14);
        push_exp(4, 1, 32'h18);
        push_exp(7, 0, 32'h10);
        run_burst(32'h10, 32'h4, 16'd10, 2'b10, 7, 4, 8, 1'b1, 16'd3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
